// File: rtl/instr_fetch.sv
// instr_fetch: per-core fetch stage; reads one- or two-byte instructions byte by byte
// from the shared memory controller and hands {opcode, operand} to the decoder.
module instr_fetch #(
  parameter int          RD_LAT   = 1,
  parameter logic [7:0]  PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  input  logic        halt,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  typedef enum logic [2:0] {IDLE, REQ_OP, WAIT_OP, REQ_ARG, WAIT_ARG, OUT} state_e;
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d, ipc_q, ipc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] instr_q, instr_d;
  logic        lat_done;
  assign lat_done    = cnt_q == LAT_M1;
  assign mem_req     = state_q == REQ_OP || state_q == REQ_ARG;
  assign mem_addr    = pc_q;
  assign instr_valid = state_q == OUT;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  // instr/instr_pc are only observable in OUT, so they double as the opcode holding register
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (jump_en) begin
      pc_d    = jump_addr;
      cnt_d   = 2'd0;
      state_d = halt ? IDLE : REQ_OP;
    end else begin
      case (state_q)
        IDLE: state_d = halt ? IDLE : REQ_OP;
        REQ_OP, REQ_ARG: begin
          state_d = mem_ack ? (state_q == REQ_OP ? WAIT_OP : WAIT_ARG) : state_q;
          cnt_d   = mem_ack ? 2'd0 : cnt_q;
        end
        WAIT_OP: begin
          cnt_d   = lat_done ? cnt_q : cnt_q + 2'd1;
          pc_d    = lat_done ? pc_q + 8'd1 : pc_q;
          instr_d = lat_done ? {mem_rdata, 8'h00} : instr_q;
          ipc_d   = lat_done ? pc_q : ipc_q;
          state_d = !lat_done ? WAIT_OP : (mem_rdata[7] ? REQ_ARG : OUT);
        end
        WAIT_ARG: begin
          cnt_d   = lat_done ? cnt_q : cnt_q + 2'd1;
          pc_d    = lat_done ? pc_q + 8'd1 : pc_q;
          instr_d = lat_done ? {instr_q[15:8], mem_rdata} : instr_q;
          state_d = lat_done ? OUT : WAIT_ARG;
        end
        OUT: state_d = instr_ready ? (halt ? IDLE : REQ_OP) : OUT;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      cnt_q   <= 2'd0;
      instr_q <= 16'h0000;
      ipc_q   <= PC_RESET;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end
endmodule
